// File: rtl/axis_square_pkg.sv
// axis_square_pkg: shared constants and helpers for the axis_square_pipe squarer.
//   prod_w()   - width of the full signed square for a given sample width
//   PIPE_MIN/PIPE_MAX - legal range of accept-to-output latency
//   fit()      - fits the shifted square to the output width; truncates by
//                default, saturates to all ones when AXIS_SQUARE_SAT_EN is defined
package axis_square_pkg;

   localparam int unsigned PIPE_MIN = 2;
   localparam int unsigned PIPE_MAX = 4;

   // Widest shifted square the fitter ever sees (DATA_W tops out at 32).
   localparam int unsigned FIT_W = 64;

   function automatic int unsigned prod_w(input int unsigned data_w);
      return 2 * data_w;
   endfunction

   // Result is valid in its low out_w bits; higher bits are zero.
   function automatic logic [FIT_W-1:0] fit(input logic [FIT_W-1:0] q,
                                            input int unsigned     out_w);
      logic [FIT_W-1:0] ones;
      logic [FIT_W-1:0] mask;
      ones = '1;
      // A shift of FIT_W or more yields zero, so out_w == FIT_W gives a full mask.
      mask = ~(ones << out_w);
`ifdef AXIS_SQUARE_SAT_EN
      if ((q & ~mask) != '0) begin
         return mask;
      end
      return q & mask;
`else
      return q & mask;
`endif
   endfunction

endpackage

// File: rtl/axis_square_pipe_core.sv
// square_core: ce-gated squaring pipeline.
//   Stage 1 registers the input sample, valid and last; stages 2..PIPE_STAGES
//   register the full-width square. All stages advance together when ce=1 and
//   hold everything when ce=0.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   ce                  - pipeline advance enable
//   in_valid/data/last  - sample entering stage 1
//   out_valid/data/last - unsigned square leaving the last stage
module square_core
   import axis_square_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned PIPE_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ce,
   input  logic                          in_valid,
   input  logic signed [DATA_W-1:0]      in_data,
   input  logic                          in_last,
   output logic                          out_valid,
   output logic [prod_w(DATA_W)-1:0]     out_data,
   output logic                          out_last
);

   localparam int unsigned PROD_W = prod_w(DATA_W);
   localparam int unsigned NPROD  = PIPE_STAGES - 1;

   logic                     in_v_q;
   logic                     in_l_q;
   logic signed [DATA_W-1:0] in_d_q;

   logic [NPROD-1:0]  v_sr;
   logic [NPROD-1:0]  l_sr;
   logic [PROD_W-1:0] p_sr [NPROD];

   logic signed [PROD_W-1:0] x_ext;
   logic [PROD_W-1:0]        sq;

   // Sign-extend before multiplying so the product is formed at full width.
   always_comb begin
      x_ext = PROD_W'(in_d_q);
      sq    = x_ext * x_ext;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_v_q <= 1'b0;
         in_l_q <= 1'b0;
         in_d_q <= '0;
         v_sr   <= '0;
         l_sr   <= '0;
         for (int unsigned i = 0; i < NPROD; i++) begin
            p_sr[i] <= '0;
         end
      end else if (ce) begin
         in_v_q  <= in_valid;
         in_l_q  <= in_last;
         in_d_q  <= in_data;
         v_sr[0] <= in_v_q;
         l_sr[0] <= in_l_q;
         p_sr[0] <= sq;
         for (int unsigned i = 1; i < NPROD; i++) begin
            v_sr[i] <= v_sr[i-1];
            l_sr[i] <= l_sr[i-1];
            p_sr[i] <= p_sr[i-1];
         end
      end
   end

   assign out_valid = v_sr[NPROD-1];
   assign out_last  = l_sr[NPROD-1];
   assign out_data  = p_sr[NPROD-1];

endmodule

// File: rtl/axis_square_pipe.sv
// axis_square_pipe: fully pipelined AXI4-Stream squarer (Pan-Tompkins chain,
// between derivative filter and moving-window integrator).
//   Emits ((x*x) >> SHIFT) fitted to OUT_W bits, one sample per cycle, with
//   tlast carried alongside. Accept-to-output latency is PIPE_STAGES cycles.
//   Define AXIS_SQUARE_SAT_EN to saturate instead of truncate on overflow.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   s_axis_tvalid/tready/tdata/tlast  - signed sample input
//   m_axis_tvalid/tready/tdata/tlast  - unsigned shifted square output
module axis_square_pipe
   import axis_square_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned OUT_W       = 32,
   parameter int unsigned SHIFT       = 0,
   parameter int unsigned PIPE_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic signed [DATA_W-1:0] s_axis_tdata,
   input  logic                     s_axis_tlast,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [OUT_W-1:0]         m_axis_tdata,
   output logic                     m_axis_tlast
);

   localparam int unsigned PROD_W = prod_w(DATA_W);

   if (DATA_W < 4 || DATA_W > 32) begin : g_bad_data_w
      $error("axis_square_pipe: DATA_W must be 4..32");
   end
   if (OUT_W < 1 || OUT_W > PROD_W) begin : g_bad_out_w
      $error("axis_square_pipe: OUT_W must be 1..2*DATA_W");
   end
   if (SHIFT >= PROD_W) begin : g_bad_shift
      $error("axis_square_pipe: SHIFT must be below 2*DATA_W");
   end
   if (PIPE_STAGES < PIPE_MIN || PIPE_STAGES > PIPE_MAX) begin : g_bad_pipe
      $error("axis_square_pipe: PIPE_STAGES must be 2..4");
   end

   logic              ce;
   logic              core_valid;
   logic              core_last;
   logic [PROD_W-1:0] core_data;

   // The whole pipe moves whenever the output slot is empty or being taken.
   assign ce            = m_axis_tready | ~core_valid;
   assign s_axis_tready = ce & ~rst;

   square_core #(
      .DATA_W      (DATA_W),
      .PIPE_STAGES (PIPE_STAGES)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_valid  (s_axis_tvalid),
      .in_data   (s_axis_tdata),
      .in_last   (s_axis_tlast),
      .out_valid (core_valid),
      .out_data  (core_data),
      .out_last  (core_last)
   );

   // Outputs are forced quiet during reset, before the registers have cleared.
   assign m_axis_tvalid = core_valid & ~rst;
   assign m_axis_tlast  = core_last & ~rst;
   assign m_axis_tdata  = rst ? '0 : OUT_W'(fit(FIT_W'(core_data >> SHIFT), OUT_W));

endmodule
